// File: rtl/bf16_op_pkg.sv
// Shared widths and types for the bf16 operand loader and the a*b + c*d operation stage.
package bf16_op_pkg;

    localparam int BF16_W      = 16;
    localparam int WORD_W      = 32;
    localparam int N_SLOTS     = 2;
    localparam int CNT_W       = $clog2(N_SLOTS + 1);
    localparam int ISSUE_CNT_W = 16;

    localparam logic [CNT_W-1:0] SLOTS_FULL = CNT_W'(N_SLOTS);

    typedef logic [BF16_W-1:0] bf16_t;

    typedef struct packed {
        bf16_t a;
        bf16_t b;
        bf16_t c;
        bf16_t d;
    } operand_set_t;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        HOLD
    } issue_state_t;

endpackage

// File: rtl/bf16_operand_slot_buf.sv
// Two-entry ring of operand sets; each set is assembled from two words ({a,b} then {c,d}).
module bf16_operand_slot_buf
    import bf16_op_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              pop_i,
    output logic [CNT_W-1:0]  count_o,
    output operand_set_t      head_set_o
);

    operand_set_t     slots_q [N_SLOTS];
    operand_set_t     slots_d [N_SLOTS];
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic             half_q, half_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;
    logic             push_complete;

    // A half-written tail slot is invisible to count, so it never issues early.
    always_comb begin
        push_ok       = push_i && (count_q != SLOTS_FULL);
        pop_ok        = pop_i && (count_q != '0);
        push_complete = push_ok && half_q;

        slots_d = slots_q;
        if (push_ok) begin
            if (half_q) begin
                slots_d[tail_q].c = word_i[WORD_W-1:BF16_W];
                slots_d[tail_q].d = word_i[BF16_W-1:0];
            end else begin
                slots_d[tail_q].a = word_i[WORD_W-1:BF16_W];
                slots_d[tail_q].b = word_i[BF16_W-1:0];
            end
        end

        half_d = half_q ^ push_ok;
        tail_d = tail_q ^ push_complete;
        head_d = head_q ^ pop_ok;

        count_d = count_q;
        if (push_complete && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_complete && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q <= '{default: '0};
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            half_q  <= 1'b0;
            count_q <= '0;
        end else begin
            slots_q <= slots_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            half_q  <= half_d;
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign head_set_o = slots_q[head_q];

endmodule

// File: rtl/bf16_operand_loader.sv
// Packs co-processor words into {a,b,c,d} sets and issues them to the bf16 operation stage,
// holding the operands stable until the stage releases BUSY.
module bf16_operand_loader
    import bf16_op_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_W-1:0]      in_word,
    input  logic                   in_STB,
    output logic                   in_BUSY,
    output bf16_t                  input_a,
    output bf16_t                  input_b,
    output bf16_t                  input_c,
    output bf16_t                  input_d,
    output logic                   op1_input_STB,
    input  logic                   op1_BUSY,
    output logic [CNT_W-1:0]       sets_pending,
    output logic [ISSUE_CNT_W-1:0] sets_issued
);

    issue_state_t           state_q;
    logic                   stb_q;
    operand_set_t           operands_q;
    operand_set_t           head_set;
    logic [CNT_W-1:0]       count;
    logic [ISSUE_CNT_W-1:0] sets_issued_q, sets_issued_d;
    logic                   word_accept;
    logic                   pop;

    assign in_BUSY     = rst || (count == SLOTS_FULL);
    assign word_accept = in_STB && !in_BUSY;
    assign pop         = (state_q == HOLD) && !op1_BUSY;

    bf16_operand_slot_buf u_slot_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (word_accept),
        .word_i     (in_word),
        .pop_i      (pop),
        .count_o    (count),
        .head_set_o (head_set)
    );

    // Operands load only when leaving IDLE; the stage reads c/d late, so they must not move in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            stb_q      <= 1'b0;
            operands_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count != '0) begin
                        operands_q <= head_set;
                        stb_q      <= 1'b1;
                        state_q    <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (op1_BUSY) begin
                        stb_q   <= 1'b0;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!op1_BUSY) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    stb_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sets_issued_d = pop ? sets_issued_q + ISSUE_CNT_W'(1) : sets_issued_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sets_issued_q <= '0;
        end else begin
            sets_issued_q <= sets_issued_d;
        end
    end

    assign input_a       = operands_q.a;
    assign input_b       = operands_q.b;
    assign input_c       = operands_q.c;
    assign input_d       = operands_q.d;
    assign op1_input_STB = stb_q;
    assign sets_pending  = count;
    assign sets_issued   = sets_issued_q;

endmodule
